// File: rtl/delay_arc_sequencer.sv
// Sequencer for characterizing a 4-input gate: walks tpdr, tpdf, tcdr and tcdf,
// applies setup/launch vectors and times the synchronized gate output per arc.
module delay_arc_sequencer #(
   parameter int SETUP_CYC  = 4,
   parameter int WINDOW_CYC = 8,
   parameter int CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             y,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             D,
   output logic             valid,
   output logic [1:0]       arc,
   output logic             busy,
   output logic             done,
   output logic             meas_valid,
   output logic [CNT_W-1:0] meas_cycles,
   output logic             meas_timeout
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SETUP  = 3'd1;
   localparam logic [2:0] S_LAUNCH = 3'd2;
   localparam logic [2:0] S_REPORT = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [CNT_W-1:0] L_SETUP_LAST = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] L_WINDOW     = CNT_W'(WINDOW_CYC);

   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_result;
   logic             r_hit;
   logic             r_ysync1;
   logic             r_ysync2;
   logic             r_yref;
   logic [3:0]       r_stim;
   logic [1:0]       r_arc;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic             r_meas_valid;
   logic [CNT_W-1:0] r_meas_cycles;
   logic             r_meas_timeout;
   logic             w_change;

   // Stimulus table, {A,B,C,D}
   function automatic logic [3:0] setup_vec(input logic [1:0] a);
      case (a)
         2'd0:    setup_vec = 4'b0000;
         2'd1:    setup_vec = 4'b1111;
         2'd2:    setup_vec = 4'b0011;
         default: setup_vec = 4'b0101;
      endcase
   endfunction

   function automatic logic [3:0] launch_vec(input logic [1:0] a);
      case (a)
         2'd0:    launch_vec = 4'b1010;
         2'd1:    launch_vec = 4'b0011;
         2'd2:    launch_vec = 4'b1111;
         default: launch_vec = 4'b0000;
      endcase
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ysync1 <= 1'b0;
         r_ysync2 <= 1'b0;
      end else begin
         r_ysync1 <= y;
         r_ysync2 <= r_ysync1;
      end
   end

   // Only the first departure from the reference counts within a window
   assign w_change = (r_ysync2 != r_yref) && !r_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_result       <= '0;
         r_hit          <= 1'b0;
         r_yref         <= 1'b0;
         r_stim         <= 4'b0000;
         r_arc          <= 2'd0;
         r_valid        <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_meas_valid   <= 1'b0;
         r_meas_cycles  <= '0;
         r_meas_timeout <= 1'b0;
      end else begin
         r_meas_valid <= 1'b0;
         r_done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_SETUP;
                  r_arc   <= 2'd0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_stim  <= setup_vec(2'd0);
               end
            end
            S_SETUP: begin
               if (r_cnt == L_SETUP_LAST) begin
                  r_state <= S_LAUNCH;
                  r_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
                  r_yref  <= r_ysync2;
                  r_hit   <= 1'b0;
                  r_stim  <= launch_vec(r_arc);
                  r_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_LAUNCH: begin
               if (w_change) begin
                  r_hit    <= 1'b1;
                  r_result <= r_cnt;
               end
               if (r_cnt == L_WINDOW) begin
                  r_state      <= S_REPORT;
                  r_valid      <= 1'b0;
                  r_meas_valid <= 1'b1;
                  // A change seen in the last window cycle still counts
                  if (r_hit) begin
                     r_meas_cycles  <= r_result;
                     r_meas_timeout <= 1'b0;
                  end else if (w_change) begin
                     r_meas_cycles  <= r_cnt;
                     r_meas_timeout <= 1'b0;
                  end else begin
                     r_meas_cycles  <= L_WINDOW;
                     r_meas_timeout <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_REPORT: begin
               if (r_arc == 2'd3) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_state <= S_SETUP;
                  r_arc   <= r_arc + 2'd1;
                  r_cnt   <= '0;
                  r_stim  <= setup_vec(r_arc + 2'd1);
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_arc   <= 2'd0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign A            = r_stim[3];
   assign B            = r_stim[2];
   assign C            = r_stim[1];
   assign D            = r_stim[0];
   assign valid        = r_valid;
   assign arc          = r_arc;
   assign busy         = r_busy;
   assign done         = r_done;
   assign meas_valid   = r_meas_valid;
   assign meas_cycles  = r_meas_cycles;
   assign meas_timeout = r_meas_timeout;

endmodule

// File: tb/tb_delay_arc_sequencer.sv
// Directed bench for delay_arc_sequencer: per-cycle timeline check of full runs
// with several y behaviours, plus start-held, start-while-busy and mid-run reset.
module tb_delay_arc_sequencer;

   localparam int CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             y;
   logic             A, B, C, D;
   logic             valid;
   logic [1:0]       arc;
   logic             busy;
   logic             done;
   logic             meas_valid;
   logic [CNT_W-1:0] meas_cycles;
   logic             meas_timeout;

   int checks   = 0;
   int failures = 0;

   // y driver: 0 = gate model (y follows stimulus in the 2nd cycle), 1 = tied 0,
   // 2 = high for launch cycles 3..5 only
   int   y_mode = 0;
   int   lc     = 0;
   logic f_prev = 1'b0;

   typedef struct {
      logic [3:0] setup_v;
      logic [3:0] launch_v;
   } vec_t;

   typedef struct {
      int   mode;
      int   exp_cyc;
      logic exp_to;
      bit   mid_start;
   } run_t;

   vec_t vtab[4];
   run_t rtab[4];

   delay_arc_sequencer #(
      .SETUP_CYC (4),
      .WINDOW_CYC(8),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .y           (y),
      .A           (A),
      .B           (B),
      .C           (C),
      .D           (D),
      .valid       (valid),
      .arc         (arc),
      .busy        (busy),
      .done        (done),
      .meas_valid  (meas_valid),
      .meas_cycles (meas_cycles),
      .meas_timeout(meas_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic gate_f(input logic a, input logic b, input logic c, input logic d);
      gate_f = (a & c) | (a & d) | (b & c) | (b & d);
   endfunction

   initial y = 1'b0;
   always @(posedge clk) begin
      #1;
      lc = valid ? lc + 1 : 0;
      case (y_mode)
         0:       y = f_prev;
         1:       y = 1'b0;
         default: y = (lc >= 3 && lc < 6);
      endcase
      f_prev = gate_f(A, B, C, D);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Drives start before the next edge and checks every output for all 53 cycles
   task automatic check_run(input int exp_cyc, input logic exp_to, input bit mid_start, input bit hold);
      start = 1'b1;
      for (int n = 1; n <= 53; n++) begin
         int         a;
         int         p;
         logic [3:0] ev;
         @(posedge clk);
         #1;
         if (n == 1 && !hold) start = 1'b0;
         if (mid_start && n == 30) start = 1'b1;
         if (mid_start && n == 31) start = 1'b0;
         if (n <= 52) begin
            a  = (n - 1) / 13;
            p  = (n - 1) % 13;
            ev = (p < 4) ? vtab[a].setup_v : vtab[a].launch_v;
            chk($sformatf("stim n=%0d", n), 32'({A, B, C, D}), 32'(ev));
            chk($sformatf("arc n=%0d", n), 32'(arc), 32'(a));
            chk($sformatf("valid n=%0d", n), 32'(valid), 32'(p >= 4 && p < 12));
            chk($sformatf("busy n=%0d", n), 32'(busy), 32'd1);
            chk($sformatf("done n=%0d", n), 32'(done), 32'd0);
            chk($sformatf("meas_valid n=%0d", n), 32'(meas_valid), 32'(p == 12));
            if (p == 12) begin
               $display("report arc=%0d meas_cycles=%0d meas_timeout=%0d", arc, meas_cycles, meas_timeout);
               chk($sformatf("meas_cycles arc=%0d", a), 32'(meas_cycles), 32'(exp_cyc));
               chk($sformatf("meas_timeout arc=%0d", a), 32'(meas_timeout), 32'(exp_to));
            end
         end else begin
            $display("done pulse at cycle %0d", n);
            chk("done at 53", 32'(done), 32'd1);
            chk("busy at done", 32'(busy), 32'd0);
            chk("valid at done", 32'(valid), 32'd0);
            chk("meas_valid at done", 32'(meas_valid), 32'd0);
         end
      end
   endtask

   initial begin
      int pulses;

      vtab[0] = '{4'b0000, 4'b1010};
      vtab[1] = '{4'b1111, 4'b0011};
      vtab[2] = '{4'b0011, 4'b1111};
      vtab[3] = '{4'b0101, 4'b0000};

      rtab[0] = '{0, 4, 1'b0, 1'b0};
      rtab[1] = '{1, 8, 1'b1, 1'b0};
      rtab[2] = '{2, 5, 1'b0, 1'b0};
      rtab[3] = '{0, 4, 1'b0, 1'b1};

      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset stim", 32'({A, B, C, D}), 32'd0);
      chk("reset arc", 32'(arc), 32'd0);
      chk("reset valid", 32'(valid), 32'd0);
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset meas_valid", 32'(meas_valid), 32'd0);
      chk("reset meas_cycles", 32'(meas_cycles), 32'd0);
      chk("reset meas_timeout", 32'(meas_timeout), 32'd0);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle busy", 32'(busy), 32'd0);

      for (int i = 0; i < 4; i++) begin
         y_mode = rtab[i].mode;
         $display("run %0d y_mode=%0d mid_start=%0d", i, rtab[i].mode, rtab[i].mid_start);
         check_run(rtab[i].exp_cyc, rtab[i].exp_to, rtab[i].mid_start, 1'b0);
         @(posedge clk);
         #1;
         chk("post-run done", 32'(done), 32'd0);
         chk("post-run busy", 32'(busy), 32'd0);
      end

      // start held high across DONE: one idle cycle, then a new run
      y_mode = 0;
      check_run(4, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      chk("held idle busy", 32'(busy), 32'd0);
      chk("held idle done", 32'(done), 32'd0);
      check_run(4, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("held post busy", 32'(busy), 32'd0);

      // Reset during arc1 LAUNCH
      start = 1'b1;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (n == 1) start = 1'b0;
      end
      chk("pre-reset arc", 32'(arc), 32'd1);
      chk("pre-reset valid", 32'(valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async stim", 32'({A, B, C, D}), 32'd0);
      chk("async valid", 32'(valid), 32'd0);
      chk("async busy", 32'(busy), 32'd0);
      chk("async arc", 32'(arc), 32'd0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      pulses = 0;
      for (int n = 0; n < 60; n++) begin
         @(posedge clk);
         #1;
         if (done || meas_valid || busy) pulses++;
      end
      chk("no activity after reset", 32'(pulses), 32'd0);
      check_run(4, 1'b0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
